// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage feeding the 32x64 register file.
// Issues one load/store at a time over an ack-based port and stalls EX until it completes or times out.
module mem_wb_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic              in_wr_en,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_ppp,
    input  logic [63:0]       in_result,
    input  logic [63:0]       in_store_data,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [63:0]       dmem_rdata,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [63:0]       wb_data,
    output logic [2:0]        wb_ppp,
    output logic              err_ppp,
    output logic              err_timeout
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     state;
    logic [CNT_W-1:0] cnt;
    logic       cap_load;
    logic       cap_wb_ok;
    logic [4:0] cap_rd;
    logic [2:0] cap_ppp;

    logic in_ppp_ok;
    logic in_is_mem;
    logic in_wb_ok;

    // Codes above 100 have no defined participation pattern.
    assign in_ppp_ok = (in_ppp <= 3'b100);
    assign in_is_mem = in_is_load || in_is_store;
    assign in_wb_ok  = in_wr_en && (in_rd != 5'd0) && in_ppp_ok;

    assign stall = (state == S_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cap_load    <= 1'b0;
            cap_wb_ok   <= 1'b0;
            cap_rd      <= '0;
            cap_ppp     <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            wb_ppp      <= '0;
            err_ppp     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            if (state == S_IDLE) begin
                if (in_valid) begin
                    if (!in_ppp_ok) begin
                        err_ppp <= 1'b1;
                    end
                    if (in_is_mem) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= in_is_store && !in_is_load;
                        dmem_addr  <= in_result[ADDR_W-1:0];
                        dmem_wdata <= in_store_data;
                        cap_load   <= in_is_load;
                        cap_wb_ok  <= in_wb_ok;
                        cap_rd     <= in_rd;
                        cap_ppp    <= in_ppp;
                        cnt        <= '0;
                        state      <= S_WAIT;
                    end else if (in_wb_ok) begin
                        wb_en   <= 1'b1;
                        wb_addr <= in_rd;
                        wb_data <= in_result;
                        wb_ppp  <= in_ppp;
                    end
                end
            end else begin
                // Ack on the final allowed cycle still counts as a normal completion.
                if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    state    <= S_IDLE;
                    if (cap_load && cap_wb_ok) begin
                        wb_en   <= 1'b1;
                        wb_addr <= cap_rd;
                        wb_data <= dmem_rdata;
                        wb_ppp  <= cap_ppp;
                    end
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    dmem_req    <= 1'b0;
                    state       <= S_IDLE;
                    err_timeout <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; expected write-backs are queued at issue and
// matched by a negedge monitor, other outputs checked inline.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_is_load, in_is_store, in_wr_en;
    logic [4:0]  in_rd;
    logic [2:0]  in_ppp;
    logic [63:0] in_result, in_store_data;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic [2:0]  wb_ppp;
    logic        err_ppp, err_timeout;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
        logic [2:0]  ppp;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    mem_wb_stage #(.ADDR_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_wr_en(in_wr_en), .in_rd(in_rd), .in_ppp(in_ppp),
        .in_result(in_result), .in_store_data(in_store_data),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ppp(wb_ppp),
        .err_ppp(err_ppp), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_is_load = 0; in_is_store = 0; in_wr_en = 0;
        in_rd = '0; in_ppp = '0; in_result = '0; in_store_data = '0;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic we, input logic [4:0] rd,
                            input logic [2:0] ppp, input logic [63:0] res, input logic [63:0] sd);
        in_valid = 1; in_is_load = ld; in_is_store = st; in_wr_en = we;
        in_rd = rd; in_ppp = ppp; in_result = res; in_store_data = sd;
    endtask

    always @(negedge clk) begin
        if (reset && wb_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb_en", {59'd0, wb_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_addr", {59'd0, wb_addr}, {59'd0, e.addr});
                check("wb_data", wb_data, e.data);
                check("wb_ppp", {61'd0, wb_ppp}, {61'd0, e.ppp});
            end
        end
    end

    initial begin
        int n;
        int stall_cycles;
        reset = 0; dmem_ack = 0; dmem_rdata = '0;
        idle_inputs();
        #12;
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_req", {63'd0, dmem_req}, 64'd0);
        check("rst_wb_en", {63'd0, wb_en}, 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_errs", {62'd0, err_ppp, err_timeout}, 64'd0);
        step();
        reset = 1;
        step();

        // ALU ops back to back
        drive_op(0, 0, 1, 5'd5, 3'b000, 64'h1122_3344_5566_7788, 64'd0);
        exp_q.push_back('{5'd5, 64'h1122_3344_5566_7788, 3'b000});
        step();
        check("alu_stall", {63'd0, stall}, 64'd0);
        drive_op(0, 0, 1, 5'd9, 3'b001, 64'h0000_0000_CAFE_0009, 64'd0);
        exp_q.push_back('{5'd9, 64'h0000_0000_CAFE_0009, 3'b001});
        step();
        drive_op(0, 0, 1, 5'd10, 3'b100, 64'hFEDC_BA98_7654_3210, 64'd0);
        exp_q.push_back('{5'd10, 64'hFEDC_BA98_7654_3210, 3'b100});
        step();
        idle_inputs();
        step();

        // Load, ack 3 cycles after request; inputs during stall must be ignored
        drive_op(1, 0, 1, 5'd7, 3'b010, 64'h100, 64'd0);
        step();
        stall_cycles = 0;
        if (stall) stall_cycles++;
        check("ld_req", {63'd0, dmem_req}, 64'd1);
        check("ld_we", {63'd0, dmem_we}, 64'd0);
        check("ld_addr", {32'd0, dmem_addr}, 64'h100);
        drive_op(0, 0, 1, 5'd12, 3'b000, 64'h12, 64'd0);
        step();
        if (stall) stall_cycles++;
        step();
        if (stall) stall_cycles++;
        idle_inputs();
        step();
        if (stall) stall_cycles++;
        dmem_ack = 1; dmem_rdata = 64'hDEAD_BEEF_0000_0001;
        exp_q.push_back('{5'd7, 64'hDEAD_BEEF_0000_0001, 3'b010});
        step();
        dmem_ack = 0;
        check("ld_stall_cycles", 64'(stall_cycles), 64'd4);
        check("ld_stall_after", {63'd0, stall}, 64'd0);
        check("ld_wb_en", {63'd0, wb_en}, 64'd1);
        step();

        // Store; next ALU op held upstream during stall
        drive_op(0, 1, 1, 5'd2, 3'b000, 64'h40, 64'hAA);
        step();
        check("st_req", {63'd0, dmem_req}, 64'd1);
        check("st_we", {63'd0, dmem_we}, 64'd1);
        check("st_addr", {32'd0, dmem_addr}, 64'h40);
        check("st_wdata", dmem_wdata, 64'hAA);
        drive_op(0, 0, 1, 5'd4, 3'b000, 64'hD4, 64'd0);
        step();
        check("st_req_held", {63'd0, dmem_req}, 64'd1);
        step();
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        check("st_req_drop", {63'd0, dmem_req}, 64'd0);
        check("st_stall_drop", {63'd0, stall}, 64'd0);
        check("st_no_wb", {63'd0, wb_en}, 64'd0);
        exp_q.push_back('{5'd4, 64'hD4, 3'b000});
        step();
        idle_inputs();
        check("st_next_wb", {63'd0, wb_en}, 64'd1);
        step();

        // Ack on the last allowed WAIT cycle completes normally
        drive_op(1, 0, 1, 5'd13, 3'b011, 64'h200, 64'd0);
        step();
        idle_inputs();
        for (int i = 0; i < 63; i++) step();
        check("late_req_still", {63'd0, dmem_req}, 64'd1);
        dmem_ack = 1; dmem_rdata = 64'h0BAD_F00D_1234_5678;
        exp_q.push_back('{5'd13, 64'h0BAD_F00D_1234_5678, 3'b011});
        step();
        dmem_ack = 0;
        check("late_no_timeout", {63'd0, err_timeout}, 64'd0);
        check("late_wb_en", {63'd0, wb_en}, 64'd1);
        step();

        // Load never acked -> timeout
        drive_op(1, 0, 1, 5'd8, 3'b000, 64'h300, 64'd0);
        step();
        idle_inputs();
        n = 0;
        while (dmem_req && n < 200) begin
            n++;
            step();
        end
        check("to_req_cycles", 64'(n), 64'd64);
        check("to_err", {63'd0, err_timeout}, 64'd1);
        check("to_stall", {63'd0, stall}, 64'd0);
        check("to_wb_en", {63'd0, wb_en}, 64'd0);
        step();

        // Illegal ppp, then rd=0
        drive_op(0, 0, 1, 5'd3, 3'b110, 64'h33, 64'd0);
        step();
        check("ppp_err", {63'd0, err_ppp}, 64'd1);
        check("ppp_no_wb", {63'd0, wb_en}, 64'd0);
        drive_op(0, 0, 1, 5'd0, 3'b000, 64'h44, 64'd0);
        step();
        idle_inputs();
        check("rd0_no_wb", {63'd0, wb_en}, 64'd0);
        check("ppp_sticky", {63'd0, err_ppp}, 64'd1);
        check("hold_wb_addr", {59'd0, wb_addr}, 64'd13);
        step();

        // Reset in the middle of WAIT
        drive_op(1, 0, 1, 5'd6, 3'b000, 64'h500, 64'd0);
        step();
        idle_inputs();
        step();
        reset = 0;
        #1;
        check("mid_rst_req", {63'd0, dmem_req}, 64'd0);
        check("mid_rst_stall", {63'd0, stall}, 64'd0);
        check("mid_rst_wb_en", {63'd0, wb_en}, 64'd0);
        check("mid_rst_errs", {62'd0, err_ppp, err_timeout}, 64'd0);
        step();
        reset = 1;
        step();
        drive_op(0, 0, 1, 5'd11, 3'b000, 64'h1111, 64'd0);
        exp_q.push_back('{5'd11, 64'h1111, 3'b000});
        step();
        idle_inputs();
        check("post_rst_wb_en", {63'd0, wb_en}, 64'd1);
        step();
        step();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
